// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Input-side conditioner for the four board pushbuttons. Each raw key goes
// through a polarity fix, a two-flop synchroniser and a debounce counter.
// A new level is accepted only after it has been seen at the synchroniser
// output for DEBOUNCE_CYCLES consecutive cycles. Every accepted transition
// produces a registered one-cycle press or release pulse for that lane.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level
//                    (legal range 1 .. 2^CNT_W-1)
//   CNT_W            width of each per-lane debounce counter
//   RAW_ACTIVE_LOW   1: raw key reads 0 when pressed, 0: reads 1 when pressed
//
// Ports:
//   clk            in   1  system clock, all state on rising edge
//   rst            in   1  synchronous active-high reset
//   key_raw        in   4  asynchronous raw keys (0 red, 1 green, 2 blue,
//                          3 yellow)
//   button_red     out  1  debounced level of lane 0, 1 = pressed
//   button_green   out  1  debounced level of lane 1, 1 = pressed
//   button_blue    out  1  debounced level of lane 2, 1 = pressed
//   button_yellow  out  1  debounced level of lane 3, 1 = pressed
//   press          out  4  one-cycle pulse per lane on released->pressed
//   release_o      out  4  one-cycle pulse per lane on pressed->released
//                          ("release" is a reserved word, hence the suffix)
//
// Lane behaviour, per cycle:
//   sync2 == stable               -> counter cleared
//   sync2 != stable, cnt == LAST  -> stable takes sync2, counter cleared,
//                                    press or release pulses next cycle
//   sync2 != stable, otherwise    -> counter increments
// Because the counter clears whenever sync2 returns to the stable level,
// partial counts never carry over and the counter never exceeds LAST.
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_raw,
    output logic       button_red,
    output logic       button_green,
    output logic       button_blue,
    output logic       button_yellow,
    output logic [3:0] press,
    output logic [3:0] release_o
);

    localparam int unsigned LANES = 4;

    // Terminal count: the cycle on which a differing level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Polarity is normalised before synchronisation so that everything
    // downstream works with 1 = pressed.
    logic [LANES-1:0] pressed_raw;
    assign pressed_raw = key_raw ^ {LANES{RAW_ACTIVE_LOW}};

    // Synchroniser flops; only sync2_q is used by the debounce logic.
    logic [LANES-1:0] sync1_q;
    logic [LANES-1:0] sync2_q;

    // Per-lane debounce state.
    logic [LANES-1:0] stable_q;
    logic [LANES-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q [LANES];
    logic [CNT_W-1:0] cnt_d [LANES];

    // Registered event pulses.
    logic [LANES-1:0] press_q;
    logic [LANES-1:0] press_d;
    logic [LANES-1:0] release_q;
    logic [LANES-1:0] release_d;

    // -------------------------------------------------------------------------
    // Synchroniser
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pressed_raw;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce next-state logic, four independent identical lanes
    // -------------------------------------------------------------------------
    always_comb begin
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < LANES; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    // Window complete: accept the new level and flag the
                    // direction. Counter returns to zero via the default.
                    stable_d[i]  = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Debounce state registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: straight from registers, no combinational path from key_raw
    // -------------------------------------------------------------------------
    assign button_red    = stable_q[0];
    assign button_green  = stable_q[1];
    assign button_blue   = stable_q[2];
    assign button_yellow = stable_q[3];
    assign press         = press_q;
    assign release_o     = release_q;

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Two instances: u_dut (DEBOUNCE_CYCLES=4, active-low keys) carries the main
// directed sequence; u_fast (DEBOUNCE_CYCLES=1, active-high keys) covers the
// minimum-window boundary. Stimulus pushes the expected pulse event (cycle,
// press, release, levels after the event) into a queue per instance; a
// monitor per instance pops and compares whenever the DUT shows a pulse.
//
// Cycle numbering: cyc counts rising edges. Inputs change on the falling
// edge while cyc == c, so the first edge that samples them is c+1 (edge k).
// A level is accepted at edge k+D+1, i.e. observed at cyc == c+D+2.
// -----------------------------------------------------------------------------
module tb_button_debounce;

    localparam int W = 32;  // [31:12] cycle, [11:8] press, [7:4] release, [3:0] levels

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- DUTs
    logic [3:0] key_raw = 4'b0000;
    logic       button_red, button_green, button_blue, button_yellow;
    logic [3:0] press, release_o;

    button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16),
        .RAW_ACTIVE_LOW (1'b1)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .key_raw      (key_raw),
        .button_red   (button_red),
        .button_green (button_green),
        .button_blue  (button_blue),
        .button_yellow(button_yellow),
        .press        (press),
        .release_o    (release_o)
    );

    logic [3:0] key_fast = 4'b0000;
    logic       f_red, f_green, f_blue, f_yellow;
    logic [3:0] f_press, f_release;

    button_debounce #(
        .DEBOUNCE_CYCLES(1),
        .CNT_W          (4),
        .RAW_ACTIVE_LOW (1'b0)
    ) u_fast (
        .clk          (clk),
        .rst          (rst),
        .key_raw      (key_fast),
        .button_red   (f_red),
        .button_green (f_green),
        .button_blue  (f_blue),
        .button_yellow(f_yellow),
        .press        (f_press),
        .release_o    (f_release)
    );

    logic [3:0] btn, f_btn;
    assign btn   = {button_yellow, button_blue, button_green, button_red};
    assign f_btn = {f_yellow, f_blue, f_green, f_red};

    // ---------------------------------------------------------------- scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_f_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the main instance.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if ((press | release_o) != 4'b0000) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: press=%b release=%b cyc=%0d", press, release_o, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle",   32'(cyc),     32'(e[31:12]));
                check("pulse_press",   32'(press),     32'(e[11:8]));
                check("pulse_release", 32'(release_o), 32'(e[7:4]));
                check("pulse_levels",  32'(btn),       32'(e[3:0]));
            end
        end
    end

    // Monitor for the minimum-window instance.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if ((f_press | f_release) != 4'b0000) begin
            if (exp_f_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fast_unexpected_pulse: press=%b release=%b cyc=%0d", f_press, f_release, cyc);
            end else begin
                e = exp_f_q.pop_front();
                check("fast_cycle",   32'(cyc),       32'(e[31:12]));
                check("fast_press",   32'(f_press),   32'(e[11:8]));
                check("fast_release", 32'(f_release), 32'(e[7:4]));
                check("fast_levels",  32'(f_btn),     32'(e[3:0]));
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected event for u_dut: accepted D+2 = 6 cycles after the drive.
    task automatic expect_main(input logic [3:0] p, input logic [3:0] r, input logic [3:0] lv);
        logic [19:0] c;
        c = 20'(cyc + 6);
        exp_q.push_back({c, p, r, lv});
    endtask

    // Expected event for u_fast: accepted D+2 = 3 cycles after the drive.
    task automatic expect_fast(input logic [3:0] p, input logic [3:0] r, input logic [3:0] lv);
        logic [19:0] c;
        c = 20'(cyc + 3);
        exp_f_q.push_back({c, p, r, lv});
    endtask

    task automatic check_quiet(input string name);
        check({name, "_levels"},  32'(btn),       32'h0);
        check({name, "_press"},   32'(press),     32'h0);
        check({name, "_release"}, 32'(release_o), 32'h0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // Reset with all keys held (active-low 0000 = all pressed).
        rst     = 1'b1;
        key_raw = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            check_quiet("in_reset");
        end
        wait_cyc(1);
        rst = 1'b0;
        expect_main(4'b1111, 4'b0000, 4'b1111);
        wait_cyc(1);
        check_quiet("after_reset");
        wait_cyc(9);

        // Release everything.
        key_raw = 4'b1111;
        expect_main(4'b0000, 4'b1111, 4'b0000);
        wait_cyc(10);

        // Clean press and release of red.
        key_raw = 4'b1110;
        expect_main(4'b0001, 4'b0000, 4'b0001);
        wait_cyc(10);
        key_raw = 4'b1111;
        expect_main(4'b0000, 4'b0001, 4'b0000);
        wait_cyc(10);

        // Bouncing green: 3 low, 1 high, 3 low, 1 high, then steady low.
        key_raw = 4'b1101;
        wait_cyc(3);
        key_raw = 4'b1111;
        wait_cyc(1);
        key_raw = 4'b1101;
        wait_cyc(3);
        key_raw = 4'b1111;
        wait_cyc(1);
        check("bounce_levels", 32'(btn), 32'h0);
        key_raw = 4'b1101;
        expect_main(4'b0010, 4'b0000, 4'b0010);
        wait_cyc(10);
        key_raw = 4'b1111;
        expect_main(4'b0000, 4'b0010, 4'b0000);
        wait_cyc(10);

        // Blue held, 2-cycle release glitch filtered, then real release.
        key_raw = 4'b1011;
        expect_main(4'b0100, 4'b0000, 4'b0100);
        wait_cyc(10);
        key_raw = 4'b1111;
        wait_cyc(2);
        key_raw = 4'b1011;
        wait_cyc(8);
        check("glitch_levels", 32'(btn), 32'h4);
        key_raw = 4'b1111;
        expect_main(4'b0000, 4'b0100, 4'b0000);
        wait_cyc(10);

        // Simultaneous: green held, then red+yellow pressed as green released.
        key_raw = 4'b1101;
        expect_main(4'b0010, 4'b0000, 4'b0010);
        wait_cyc(10);
        key_raw = 4'b0110;
        expect_main(4'b1001, 4'b0010, 4'b1001);
        wait_cyc(10);
        key_raw = 4'b1111;
        expect_main(4'b0000, 4'b1001, 4'b0000);
        wait_cyc(10);

        // Mid-count reset: yellow pressed, rst after two counted cycles.
        key_raw = 4'b0111;
        wait_cyc(4);
        rst = 1'b1;
        wait_cyc(1);
        check("midrst_yellow_a", 32'(button_yellow), 32'h0);
        wait_cyc(1);
        check("midrst_yellow_b", 32'(button_yellow), 32'h0);
        rst = 1'b0;
        expect_main(4'b1000, 4'b0000, 4'b1000);
        wait_cyc(10);
        key_raw = 4'b1111;
        expect_main(4'b0000, 4'b1000, 4'b0000);
        wait_cyc(10);

        // Minimum window (DEBOUNCE_CYCLES=1, active-high keys).
        key_fast = 4'b0001;
        expect_fast(4'b0001, 4'b0000, 4'b0001);
        wait_cyc(6);
        key_fast = 4'b0110;
        expect_fast(4'b0110, 4'b0001, 4'b0110);
        wait_cyc(6);
        key_fast = 4'b0000;
        expect_fast(4'b0000, 4'b0110, 4'b0000);

        // Drain: bounded wait for outstanding expectations.
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && exp_f_q.size() == 0) break;
            wait_cyc(1);
        end
        wait_cyc(2);
        check("main_queue_empty", 32'(exp_q.size()),   32'h0);
        check("fast_queue_empty", 32'(exp_f_q.size()), 32'h0);

        // Report.
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
